// File: rtl/pipeline_stage_tracker.sv
// Per-stage op/func tracker for a five-stage pipeline (IF, DEC, EX, ME, WB).
// Bubbles are inserted for load-use hazards and taken branch/JAL flushes; also drives PC hold.
module pipeline_stage_tracker #(
    parameter int unsigned     IW          = 32,
    parameter int unsigned     OPW         = 4,
    parameter int unsigned     RW          = 4,
    parameter logic [OPW-1:0]  BUBBLE_OP   = 4'b0010,
    parameter logic [OPW-1:0]  BUBBLE_FUNC = 4'b0011
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [IW-1:0]  instr_in,
    input  logic           instr_valid,
    input  logic           br_taken,
    output logic           stall_out,
    output logic [OPW-1:0] IF_op,
    output logic [OPW-1:0] IF_func,
    output logic [OPW-1:0] DEC_op,
    output logic [OPW-1:0] DEC_func,
    output logic [OPW-1:0] EX_op,
    output logic [OPW-1:0] EX_func,
    output logic [OPW-1:0] ME_op,
    output logic [OPW-1:0] ME_func,
    output logic [OPW-1:0] WB_op,
    output logic [OPW-1:0] WB_func,
    output logic [RW-1:0]  EX_rd
);

    localparam int unsigned FUNC_MSB = IW - OPW - 1;
    localparam int unsigned RD_MSB   = FUNC_MSB - OPW;
    localparam int unsigned RS1_MSB  = RD_MSB - RW;
    localparam int unsigned RS2_MSB  = RS1_MSB - RW;
    localparam int unsigned USED_LSB = RS2_MSB - RW + 1;

    localparam logic [OPW-1:0] LW_OP     = OPW'(4'b0111);
    localparam logic [OPW-1:0] BRANCH_OP = OPW'(4'b0010);
    localparam logic [OPW-1:0] JAL_OP    = OPW'(4'b0110);

    typedef struct packed {
        logic [OPW-1:0] op;
        logic [OPW-1:0] func;
        logic [RW-1:0]  rd;
        logic [RW-1:0]  rs1;
        logic [RW-1:0]  rs2;
        logic           valid;
    } stage_t;

    localparam stage_t BUBBLE = '{op: BUBBLE_OP, func: BUBBLE_FUNC,
                                  rd: '0, rs1: '0, rs2: '0, valid: 1'b0};

    stage_t r_if;
    stage_t r_dec;
    stage_t r_ex;
    stage_t r_me;
    stage_t r_wb;

    stage_t w_fetch;
    logic   w_load_use;
    logic   w_flush;
    logic   w_unused_bits;

    // Decode the incoming word; an invalid fetch becomes a bubble
    always_comb begin
        w_fetch = BUBBLE;
        if (instr_valid) begin
            w_fetch.op    = instr_in[IW-1 -: OPW];
            w_fetch.func  = instr_in[FUNC_MSB -: OPW];
            w_fetch.rd    = instr_in[RD_MSB -: RW];
            w_fetch.rs1   = instr_in[RS1_MSB -: RW];
            w_fetch.rs2   = instr_in[RS2_MSB -: RW];
            w_fetch.valid = 1'b1;
        end
    end

    assign w_unused_bits = &{1'b0, instr_in[USED_LSB-1:0]};

    // Both source fields are compared regardless of op; over-stalling is acceptable
    assign w_load_use = r_ex.valid && (r_ex.op == LW_OP) && r_dec.valid &&
                        ((r_ex.rd == r_dec.rs1) || (r_ex.rd == r_dec.rs2));

    assign w_flush = br_taken && r_ex.valid &&
                     ((r_ex.op == BRANCH_OP) || (r_ex.op == JAL_OP));

    assign stall_out = w_load_use && !w_flush && !reset;

    // Stage advance: reset > flush > load-use stall > normal shift
    always_ff @(posedge clk) begin
        if (reset) begin
            r_if  <= BUBBLE;
            r_dec <= BUBBLE;
            r_ex  <= BUBBLE;
            r_me  <= BUBBLE;
            r_wb  <= BUBBLE;
        end else if (w_flush) begin
            r_if  <= BUBBLE;
            r_dec <= BUBBLE;
            r_ex  <= BUBBLE;
            r_me  <= r_ex;
            r_wb  <= r_me;
        end else if (w_load_use) begin
            r_ex  <= BUBBLE;
            r_me  <= r_ex;
            r_wb  <= r_me;
        end else begin
            r_if  <= w_fetch;
            r_dec <= r_if;
            r_ex  <= r_dec;
            r_me  <= r_ex;
            r_wb  <= r_me;
        end
    end

    assign IF_op    = r_if.op;
    assign IF_func  = r_if.func;
    assign DEC_op   = r_dec.op;
    assign DEC_func = r_dec.func;
    assign EX_op    = r_ex.op;
    assign EX_func  = r_ex.func;
    assign ME_op    = r_me.op;
    assign ME_func  = r_me.func;
    assign WB_op    = r_wb.op;
    assign WB_func  = r_wb.func;
    assign EX_rd    = r_ex.rd;

endmodule

// File: tb/tb_pipeline_stage_tracker.sv
// Self-checking bench for pipeline_stage_tracker: vector table, corner sequences,
// and a randomized run against a slot-list reference model.
module tb_pipeline_stage_tracker;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr_in = 32'h0;
    logic        instr_valid = 1'b0;
    logic        br_taken = 1'b0;
    logic        stall_out;
    logic [3:0]  IF_op, IF_func, DEC_op, DEC_func, EX_op, EX_func;
    logic [3:0]  ME_op, ME_func, WB_op, WB_func;
    logic [3:0]  EX_rd;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pipeline_stage_tracker dut (
        .clk(clk), .reset(reset), .instr_in(instr_in), .instr_valid(instr_valid),
        .br_taken(br_taken), .stall_out(stall_out),
        .IF_op(IF_op), .IF_func(IF_func), .DEC_op(DEC_op), .DEC_func(DEC_func),
        .EX_op(EX_op), .EX_func(EX_func), .ME_op(ME_op), .ME_func(ME_func),
        .WB_op(WB_op), .WB_func(WB_func), .EX_rd(EX_rd)
    );

    localparam logic [31:0] ADD  = 32'hC712_3000;
    localparam logic [31:0] SW   = 32'h3004_5000;
    localparam logic [31:0] CMPR = 32'hD306_7000;
    localparam logic [31:0] SUB  = 32'hC845_6000;
    localparam logic [31:0] LW3  = 32'h7030_0000;
    localparam logic [31:0] USE3 = 32'hC753_0000;
    localparam logic [31:0] JAL  = 32'h6000_0000;
    localparam logic [39:0] ALLB = 40'h23_23_23_23_23;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [31:0] instr;
        logic        br;
        logic        stall;
        logic [39:0] stages;
    } vec_t;

    typedef struct {
        int op, func, rd, rs1, rs2;
        bit v;
    } slot_t;

    function automatic logic [39:0] stages();
        return {IF_op, IF_func, DEC_op, DEC_func, EX_op, EX_func,
                ME_op, ME_func, WB_op, WB_func};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Drive one cycle; return stall_out seen before the edge
    task automatic cycle(input logic rst, input logic vld, input logic [31:0] ins,
                         input logic br, output logic st);
        reset = rst; instr_valid = vld; instr_in = ins; br_taken = br;
        @(negedge clk);
        st = stall_out;
        @(posedge clk);
        #1;
    endtask

    function automatic slot_t bub();
        slot_t s;
        s.op = 2; s.func = 3; s.rd = 0; s.rs1 = 0; s.rs2 = 0; s.v = 0;
        return s;
    endfunction

    function automatic slot_t decode(input logic [31:0] w);
        slot_t s;
        s.op = int'(w[31:28]); s.func = int'(w[27:24]); s.rd = int'(w[23:20]);
        s.rs1 = int'(w[19:16]); s.rs2 = int'(w[15:12]); s.v = 1;
        return s;
    endfunction

    vec_t  tbl[19];
    slot_t m[5];

    initial begin
        logic st;
        tbl[0]  = '{1, 0, 0,    0, 0, ALLB};
        for (int i = 1; i <= 5; i++) tbl[i] = '{0, 0, 0, 0, 0, ALLB};
        tbl[6]  = '{0, 1, ADD,  0, 0, 40'hC7_23_23_23_23};
        tbl[7]  = '{0, 1, SW,   0, 0, 40'h30_C7_23_23_23};
        tbl[8]  = '{0, 1, CMPR, 0, 0, 40'hD3_30_C7_23_23};
        tbl[9]  = '{0, 0, 0,    0, 0, 40'h23_D3_30_C7_23};
        tbl[10] = '{0, 0, 0,    0, 0, 40'h23_23_D3_30_C7};
        tbl[11] = '{0, 0, 0,    0, 0, 40'h23_23_23_D3_30};
        tbl[12] = '{0, 1, ADD,  0, 0, 40'hC7_23_23_23_D3};
        tbl[13] = '{0, 0, SUB,  0, 0, 40'h23_C7_23_23_23};
        tbl[14] = '{0, 1, SUB,  0, 0, 40'hC8_23_C7_23_23};
        tbl[15] = '{0, 0, 0,    0, 0, 40'h23_C8_23_C7_23};
        tbl[16] = '{0, 0, 0,    0, 0, 40'h23_23_C8_23_C7};
        tbl[17] = '{0, 0, 0,    0, 0, 40'h23_23_23_C8_23};
        tbl[18] = '{0, 0, 0,    0, 0, 40'h23_23_23_23_C8};

        @(posedge clk); #1;
        for (int i = 0; i < 19; i++) begin
            cycle(tbl[i].rst, tbl[i].vld, tbl[i].instr, tbl[i].br, st);
            check($sformatf("vec%0d_stall", i), 64'(st), 64'(tbl[i].stall));
            check($sformatf("vec%0d_stages", i), 64'(stages()), 64'(tbl[i].stages));
        end

        // Load-use: LW r3 then a consumer of r3
        cycle(1, 0, 0, 0, st);
        cycle(0, 1, LW3, 0, st);
        cycle(0, 1, USE3, 0, st);
        cycle(0, 0, 0, 0, st);
        check("lu_ex_rd", 64'(EX_rd), 64'd3);
        check("lu_no_early_stall", 64'(st), 64'd0);
        cycle(0, 0, 0, 0, st);
        check("lu_stall_on", 64'(st), 64'd1);
        check("lu_stalled_stages", 64'(stages()), 64'h23_C7_23_70_23);
        cycle(0, 0, 0, 0, st);
        check("lu_stall_one_cycle", 64'(st), 64'd0);
        check("lu_resume", 64'(stages()), 64'h23_23_C7_23_70);
        cycle(0, 0, 0, 0, st);
        check("lu_wb_not_yet", 64'(stages()), 64'h23_23_23_C7_23);
        cycle(0, 0, 0, 0, st);
        check("lu_wb_late", 64'(stages()), 64'h23_23_23_23_C7);

        // Taken JAL in EX flushes three younger stages
        cycle(1, 0, 0, 0, st);
        cycle(0, 1, JAL, 0, st);
        cycle(0, 1, ADD, 0, st);
        cycle(0, 1, SW, 0, st);
        cycle(0, 1, CMPR, 1, st);
        check("fl_stall_off", 64'(st), 64'd0);
        check("fl_stages", 64'(stages()), 64'h23_23_23_60_23);

        // br_taken while EX holds an ALU op is ignored
        cycle(1, 0, 0, 0, st);
        cycle(0, 1, ADD, 0, st);
        cycle(0, 1, SW, 0, st);
        cycle(0, 1, CMPR, 0, st);
        cycle(0, 0, 0, 1, st);
        check("br_ignored", 64'(stages()), 64'h23_D3_30_C7_23);

        // Reset while a stall is pending
        cycle(1, 0, 0, 0, st);
        cycle(0, 1, LW3, 0, st);
        cycle(0, 1, USE3, 0, st);
        cycle(0, 0, 0, 0, st);
        cycle(1, 0, 0, 0, st);
        check("rst_mid_stall_stages", 64'(stages()), 64'(ALLB));
        check("rst_mid_stall_rd", 64'(EX_rd), 64'd0);
        #3;
        check("rst_mid_stall_off", 64'(stall_out), 64'd0);
        @(posedge clk); #1;

        // Randomized run against the slot-list model
        cycle(1, 0, 0, 0, st);
        for (int k = 0; k < 5; k++) m[k] = bub();
        begin
            logic [31:0] held = 32'h0;
            logic        held_v = 1'b0;
            int ops[5] = '{7, 6, 2, 12, 3};
            for (int c = 0; c < 400; c++) begin
                logic        rst, br, vld, ld, fl, exp_st;
                logic [31:0] w;
                logic [39:0] exp_stages;
                rst = ($urandom_range(0, 49) == 0);
                br  = ($urandom_range(0, 2) == 0);
                ld  = m[2].v && m[2].op == 7 && m[1].v &&
                      (m[2].rd == m[1].rs1 || m[2].rd == m[1].rs2);
                fl  = br && m[2].v && (m[2].op == 2 || m[2].op == 6);
                exp_st = ld && !fl && !rst;
                if (exp_st) begin
                    w = held; vld = held_v;
                end else begin
                    w = {4'(ops[$urandom_range(0, 4)]), 4'($urandom_range(0, 15)),
                         4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                         4'($urandom_range(0, 3)), 12'($urandom)};
                    vld = ($urandom_range(0, 3) != 0);
                end
                held = w; held_v = vld;
                cycle(rst, vld, w, br, st);
                check($sformatf("rnd%0d_stall", c), 64'(st), 64'(exp_st));
                if (rst) begin
                    for (int k = 0; k < 5; k++) m[k] = bub();
                end else if (fl) begin
                    m[4] = m[3]; m[3] = m[2];
                    m[2] = bub(); m[1] = bub(); m[0] = bub();
                end else if (ld) begin
                    m[4] = m[3]; m[3] = m[2]; m[2] = bub();
                end else begin
                    m[4] = m[3]; m[3] = m[2]; m[2] = m[1]; m[1] = m[0];
                    m[0] = vld ? decode(w) : bub();
                end
                exp_stages = '0;
                for (int k = 0; k < 5; k++)
                    exp_stages = {exp_stages[31:0], 4'(m[k].op), 4'(m[k].func)};
                check($sformatf("rnd%0d_stages", c), 64'(stages()), 64'(exp_stages));
                check($sformatf("rnd%0d_exrd", c), 64'(EX_rd), 64'(m[2].rd));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipeline_stage_tracker.md
Name: pipeline_stage_tracker

Overview:
- Source side of the per-stage op/func interface consumed by PipelineController.
- Takes fetched instruction words and produces the five per-stage (op, func) pairs, one each for IF, DEC, EX, ME and WB, advancing them one stage per cycle.
- Inserts bubbles for load-use stalls and for taken-branch/JAL flushes.
- Sits between instruction fetch and the PipelineController; also drives PC hold.

Parameters:
- IW, 32, instruction width.
- OPW, 4, op and func field width.
- RW, 4, register specifier width (16 registers).
- BUBBLE_OP, 4'b0010, op used for a bubble (BRANCH).
- BUBBLE_FUNC, 4'b0011, func used for a bubble (F, never taken, so no register or memory write).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- instr_in  in  IW  fetched instruction word.
- instr_valid  in  1  instr_in is a real instruction this cycle.
- br_taken  in  1  branch/JAL in EX resolved taken (from EX-stage compare/allowBr path).
- stall_out  out  1  combinational; PC and fetch must hold.
- IF_op, IF_func  out  OPW each  IF-stage op/func.
- DEC_op, DEC_func  out  OPW each  DEC-stage op/func.
- EX_op, EX_func  out  OPW each  EX-stage op/func.
- ME_op, ME_func  out  OPW each  ME-stage op/func.
- WB_op, WB_func  out  OPW each  WB-stage op/func.
- EX_rd  out  RW  EX-stage destination register, for debug/forwarding.

Behaviour:
- Field extraction: op=instr[31:28], func=instr[27:24], rd=instr[23:20], rs1=instr[19:16], rs2=instr[15:12].
- Each stage register holds {op, func, rd, rs1, rs2, valid}.
- Reset (synchronous): every stage is loaded with {BUBBLE_OP, BUBBLE_FUNC}, rd/rs=0 and valid=0. EX_rd=0, stall_out=0. Reset overrides stall and flush, including mid-stream; the first post-reset instruction appears on IF one cycle after it is presented.
- Normal advance, per rising edge:
  - IF <= instr_in if instr_valid, else bubble.
  - DEC <= IF, EX <= DEC, ME <= EX, WB <= ME.
  - Latency: instr_in to IF is 1 cycle; to WB is 5 cycles.
- Load-use stall:
  - stall_out = EX.valid & (EX_op==LWOP 4'b0111) & DEC.valid & (EX.rd==DEC.rs1 | EX.rd==DEC.rs2).
  - Both rs fields are always compared, regardless of op; the resulting over-stall is accepted.
  - While stalled: IF and DEC hold, EX <= bubble, ME and WB advance. instr_in is ignored, and upstream must present the same word next cycle.
  - Stall lasts exactly one cycle, because the load leaves EX.
- Flush:
  - br_taken is honoured only when EX.valid and EX_op is BRANCH (0010) or JAL (0110); otherwise it is ignored.
  - On a flush: IF, DEC and EX <= bubble. ME <= EX, so the branch itself proceeds. WB <= ME.
  - Net effect is 3 bubbles.
- Priority: reset > flush > stall. The stall and flush conditions are mutually exclusive by construction (EX cannot be both LW and BRANCH/JAL). If both are asserted anyway, flush applies and stall_out is suppressed to 0.
- Bubbles carry valid=0 and never trigger a stall.
- Outputs are registered stage contents except stall_out.

Test Plan:
- Reset then 5 cycles of instr_valid=0 -> every stage op/func = 0010/0011, stall_out=0.
- Stream ALUR ADD (0xC7…), SW (0x30…), CMPR F (0xD3…) with no dependencies -> ALUR ADD reaches IF at cycle 1, EX at 3, WB at 5, op=1100/func=0111; no stall.
- LW rd=3 followed by ALUR with rs1=3 -> stall_out=1 for exactly one cycle, while LW is in EX. The next cycle shows EX=bubble, DEC still ALUR, ME=LWOP/0000; ALUR reaches WB one cycle later than unstalled.
- JAL in EX with br_taken=1 -> next cycle IF/DEC/EX=bubble, ME_op=0110, stall_out=0. br_taken=1 while EX holds ALUR -> ignored, normal advance.
- Reset asserted while a stall is active (LW/use pair in flight) -> next cycle all stages are bubbles, stall_out=0.
- instr_valid toggled 1,0,1 with ADD, SUB -> IF shows ADD, bubble, SUB on successive cycles; the bubble propagates to WB with wrReg-safe encoding 0010/0011.
